// File: rtl/match_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : match_frame_counter
// Brief    : Counts 101-detector matches over fixed-length frames and hands
//            each frame's count out through a one-entry valid/ready register.
// Revision : 1.0 - initial release
// ============================================================================
module match_frame_counter #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             match_in,
    input  logic             frame_sync,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_sat,
    output logic [7:0]       frame_num,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overflow
);

    localparam int POS_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [POS_W-1:0] c_last    = POS_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_acc_max = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_acc;
    logic             r_acc_sat;
    logic [7:0]       r_fnum;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_cnt_sat;
    logic [7:0]       r_frame_num;
    logic             r_overflow;

    logic             w_acc_at_max;
    logic [CNT_W-1:0] w_acc_next;
    logic             w_acc_sat_next;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;

    // Saturating accumulate; the same value is the frame result on completion.
    assign w_acc_at_max   = (r_acc == c_acc_max);
    assign w_acc_next     = (match_in && !w_acc_at_max) ? r_acc + CNT_W'(1) : r_acc;
    assign w_acc_sat_next = r_acc_sat | (match_in & w_acc_at_max);
    assign w_complete     = bit_valid && !frame_sync && (r_pos == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos     <= '0;
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
            r_fnum    <= '0;
        end else if (frame_sync) begin
            // A bit arriving with the sync is the new frame's first bit.
            r_pos     <= bit_valid ? POS_W'(1) : '0;
            r_acc     <= bit_valid ? CNT_W'(match_in) : '0;
            r_acc_sat <= 1'b0;
        end else if (bit_valid) begin
            if (r_pos == c_last) begin
                r_pos     <= '0;
                r_acc     <= '0;
                r_acc_sat <= 1'b0;
                r_fnum    <= r_fnum + 8'd1;
            end else begin
                r_pos     <= r_pos + POS_W'(1);
                r_acc     <= w_acc_next;
                r_acc_sat <= w_acc_sat_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_complete) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_complete) begin
                    if (cnt_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (cnt_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_out   <= '0;
            r_cnt_sat   <= 1'b0;
            r_frame_num <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt_out   <= w_acc_next;
                r_cnt_sat   <= w_acc_sat_next;
                r_frame_num <= r_fnum;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_sat   = r_cnt_sat;
    assign frame_num = r_frame_num;
    assign cnt_valid = (r_state == S_FULL);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_match_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_frame_counter
// Brief    : Self-checking bench for match_frame_counter (CNT_W=4 and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_frame_counter;

    localparam int FRAME_LEN = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_valid = 1'b0;
    logic       match_in = 1'b0;
    logic       frame_sync = 1'b0;
    logic       cnt_ready = 1'b1;

    logic [3:0] cnt_out4;
    logic       cnt_sat4, cnt_valid4, overflow4;
    logic [7:0] frame_num4;
    logic [1:0] cnt_out2;
    logic       cnt_sat2, cnt_valid2, overflow2;
    logic [7:0] frame_num2;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    match_frame_counter #(.FRAME_LEN(FRAME_LEN), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .match_in(match_in),
        .frame_sync(frame_sync), .cnt_out(cnt_out4), .cnt_sat(cnt_sat4),
        .frame_num(frame_num4), .cnt_valid(cnt_valid4), .cnt_ready(cnt_ready),
        .overflow(overflow4)
    );

    match_frame_counter #(.FRAME_LEN(FRAME_LEN), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .match_in(match_in),
        .frame_sync(frame_sync), .cnt_out(cnt_out2), .cnt_sat(cnt_sat2),
        .frame_num(frame_num2), .cnt_valid(cnt_valid2), .cnt_ready(cnt_ready),
        .overflow(overflow2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count raw matches per frame, saturate only when the frame ends.
    int   m_bits, m_matches, m_fnum, m_cnt4, m_cnt2, m_frame_num;
    logic m_valid, m_ovf, m_sat4, m_sat2;

    always @(posedge clk) begin
        int   total, done_fnum;
        logic done, hs;
        if (reset) begin
            m_bits = 0; m_matches = 0; m_fnum = 0;
            m_valid = 0; m_ovf = 0;
            m_cnt4 = 0; m_cnt2 = 0; m_sat4 = 0; m_sat2 = 0; m_frame_num = 0;
        end else begin
            hs = m_valid && cnt_ready;
            done = 1'b0;
            total = 0;
            done_fnum = 0;
            if (frame_sync) begin
                m_bits    = bit_valid ? 1 : 0;
                m_matches = bit_valid ? int'(match_in) : 0;
            end else if (bit_valid) begin
                m_matches += int'(match_in);
                if (m_bits == FRAME_LEN - 1) begin
                    done      = 1'b1;
                    total     = m_matches;
                    done_fnum = m_fnum;
                    m_bits    = 0;
                    m_matches = 0;
                    m_fnum    = (m_fnum + 1) % 256;
                end else begin
                    m_bits++;
                end
            end
            if (done) begin
                if (!m_valid || hs) begin
                    m_valid     = 1'b1;
                    m_cnt4      = (total > 15) ? 15 : total;
                    m_sat4      = (total > 15);
                    m_cnt2      = (total > 3) ? 3 : total;
                    m_sat2      = (total > 3);
                    m_frame_num = done_fnum;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cnt_valid4", 32'(cnt_valid4), 32'(m_valid));
            chk("overflow4",  32'(overflow4),  32'(m_ovf));
            chk("cnt_valid2", 32'(cnt_valid2), 32'(m_valid));
            chk("overflow2",  32'(overflow2),  32'(m_ovf));
            if (m_valid) begin
                chk("cnt_out4",   32'(cnt_out4),   32'(m_cnt4));
                chk("cnt_sat4",   32'(cnt_sat4),   32'(m_sat4));
                chk("frame_num4", 32'(frame_num4), 32'(m_frame_num));
                chk("cnt_out2",   32'(cnt_out2),   32'(m_cnt2));
                chk("cnt_sat2",   32'(cnt_sat2),   32'(m_sat2));
                chk("frame_num2", 32'(frame_num2), 32'(m_frame_num));
            end
        end
    end

    task automatic send(input logic m, input logic s);
        bit_valid  = 1'b1;
        match_in   = m;
        frame_sync = s;
        @(negedge clk);
        bit_valid  = 1'b0;
        match_in   = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;
    endtask

    initial begin
        logic [15:0] stream;
        logic [15:0] det;

        // Test 1: stream 1010 0000 0000 0101 through a 101 overlapping detector.
        do_reset();
        chk("rst_valid", 32'(cnt_valid4), 32'd0);
        chk("rst_cnt",   32'(cnt_out4),   32'd0);
        chk("rst_fnum",  32'(frame_num4), 32'd0);
        chk("rst_ovf",   32'(overflow4),  32'd0);
        stream = 16'b1010_0000_0000_0101;
        det = '0;
        for (int i = 2; i < 16; i++)
            det[i] = stream[15-i+2] & ~stream[15-i+1] & stream[15-i];
        cnt_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(det[i], 1'b0);
        chk("t1_valid", 32'(cnt_valid4), 32'd1);
        chk("t1_cnt",   32'(cnt_out4),   32'd2);
        chk("t1_fnum",  32'(frame_num4), 32'd0);
        chk("t1_sat",   32'(cnt_sat4),   32'd0);
        chk("t1_ovf",   32'(overflow4),  32'd0);
        idle();
        chk("t1_pulse", 32'(cnt_valid4), 32'd0);

        // Test 2: 3, 0, 5 matches with the consumer stalled.
        do_reset();
        cnt_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(i < 3, 1'b0);
        chk("t2_a_cnt",  32'(cnt_out4),   32'd3);
        chk("t2_a_fnum", 32'(frame_num4), 32'd0);
        for (int i = 0; i < 16; i++) send(1'b0, 1'b0);
        chk("t2_b_ovf",  32'(overflow4),  32'd1);
        chk("t2_b_cnt",  32'(cnt_out4),   32'd3);
        chk("t2_b_fnum", 32'(frame_num4), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) cnt_ready = 1'b1;
            send(i < 5, 1'b0);
        end
        chk("t2_c_valid", 32'(cnt_valid4), 32'd1);
        chk("t2_c_cnt",   32'(cnt_out4),   32'd5);
        chk("t2_c_fnum",  32'(frame_num4), 32'd2);
        idle();
        chk("t2_drain", 32'(cnt_valid4), 32'd0);

        // Test 3: saturation on both widths, then a clean frame.
        do_reset();
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0);
        chk("t3_cnt2", 32'(cnt_out2), 32'd3);
        chk("t3_sat2", 32'(cnt_sat2), 32'd1);
        chk("t3_cnt4", 32'(cnt_out4), 32'd15);
        chk("t3_sat4", 32'(cnt_sat4), 32'd1);
        for (int i = 0; i < 16; i++) send(i == 7, 1'b0);
        chk("t3_cnt2b", 32'(cnt_out2), 32'd1);
        chk("t3_sat2b", 32'(cnt_sat2), 32'd0);

        // Test 4: frame_sync with a matching bit at bit 9.
        do_reset();
        for (int i = 0; i < 9; i++) send(i < 4, 1'b0);
        send(1'b1, 1'b1);
        chk("t4_abort", 32'(cnt_valid4), 32'd0);
        for (int i = 0; i < 14; i++) send(1'b0, 1'b0);
        chk("t4_early", 32'(cnt_valid4), 32'd0);
        send(1'b0, 1'b0);
        chk("t4_valid", 32'(cnt_valid4), 32'd1);
        chk("t4_cnt",   32'(cnt_out4),   32'd1);
        chk("t4_fnum",  32'(frame_num4), 32'd0);

        // Test 5: half-rate bits, reset mid-frame with a result pending.
        do_reset();
        cnt_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin send(i < 2, 1'b0); idle(); end
        chk("t5_pend", 32'(cnt_valid4), 32'd1);
        for (int i = 0; i < 7; i++) begin send(1'b1, 1'b0); idle(); end
        reset = 1'b1;
        bit_valid = 1'b1;
        match_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bit_valid = 1'b0;
        match_in = 1'b0;
        chk("t5_valid", 32'(cnt_valid4), 32'd0);
        chk("t5_cnt",   32'(cnt_out4),   32'd0);
        chk("t5_sat",   32'(cnt_sat4),   32'd0);
        chk("t5_fnum",  32'(frame_num4), 32'd0);
        chk("t5_ovf",   32'(overflow4),  32'd0);
        cnt_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin send(i == 3 || i == 9, 1'b0); idle(); end
        chk("t5_early", 32'(cnt_valid4), 32'd0);
        send(1'b0, 1'b0);
        chk("t5_valid2", 32'(cnt_valid4), 32'd1);
        chk("t5_cnt2",   32'(cnt_out4),   32'd2);
        chk("t5_fnum2",  32'(frame_num4), 32'd0);
        idle();

        // Test 6: 257 frames, frame number wraps.
        do_reset();
        cnt_ready = 1'b1;
        for (int f = 0; f < 257; f++) begin
            for (int i = 0; i < 16; i++) send(i < (f % 4), 1'b0);
            chk("t6_fnum", 32'(frame_num4), 32'(f % 256));
            chk("t6_cnt",  32'(cnt_out4),   32'(f % 4));
            chk("t6_ovf",  32'(overflow4),  32'd0);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_frame_counter.md
Name: match_frame_counter

Overview:
- Downstream consumer of the 101 Mealy sequence detector.
- Samples the detector's match output once per stream bit and counts matches over fixed-length frames of FRAME_LEN bits.
- Presents each completed frame's count, with a frame sequence number, through a one-entry valid/ready output register.
- Feeds the status/readout logic that sits after the detector.

Parameters:
FRAME_LEN, 16, stream bits per frame; legal range 2..256.
CNT_W, 4, match-count width; count saturates at 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock shared with the detector.
reset  input  1  synchronous, active-high reset.
bit_valid  input  1  high for one cycle per stream bit (the cycle the detector's d_in carries a new bit).
match_in  input  1  detector output; sampled only when bit_valid=1.
frame_sync  input  1  restarts frame alignment; partial frame discarded.
cnt_out  output  CNT_W  match count of the last completed frame.
cnt_sat  output  1  set if that frame's count saturated.
frame_num  output  8  sequence number of that frame; wraps 255->0.
cnt_valid  output  1  output register holds an undelivered result.
cnt_ready  input  1  consumer accepts the result when cnt_valid && cnt_ready.
overflow  output  1  sticky: a completed frame was dropped because the output register was full.

Behaviour:
- Reset (synchronous, checked before all else): on reset=1 at a rising edge, all of the following clear to 0:
  - outputs: cnt_out, cnt_sat, frame_num, cnt_valid, overflow;
  - internal: bit position pos, accumulator acc, acc_sat, frame counter fnum.
  - FSM goes to EMPTY.
  - reset mid-frame or with a result pending discards everything.
- Accumulation, on each edge with bit_valid=1:
  - acc <= acc + match_in, saturating at 2^CNT_W-1.
  - acc_sat <= 1 if an increment is attempted while acc is at max.
  - pos increments.
- Frame completion: occurs when bit_valid=1 and pos==FRAME_LEN-1.
  - final = acc + match_in (saturating); final_sat is computed the same way.
  - pos, acc, acc_sat <= 0; fnum <= fnum+1 (8-bit wrap). fnum advances even when the frame is dropped.
- frame_sync=1:
  - pos, acc, acc_sat <= 0; fnum is unchanged.
  - If bit_valid=1 in the same cycle, that bit is the first bit of the new frame: pos<=1, acc<=match_in.
  - frame_sync overrides a completion in the same cycle; no result is produced.
- Output FSM, two states:
  - EMPTY:
    - cnt_valid=0.
    - On completion: load cnt_out=final, cnt_sat=final_sat, frame_num=fnum (pre-increment value), go to FULL.
  - FULL:
    - cnt_valid=1; cnt_out, cnt_sat, frame_num held stable until the handshake.
    - Handshake and no completion: go to EMPTY.
    - Handshake and completion in the same cycle: load the new result, stay FULL (zero-bubble).
    - Completion without handshake: result dropped, overflow<=1, register unchanged.
- overflow is cleared only by reset.
- Latency: completion at edge t -> cnt_valid=1 and data visible after edge t (1 cycle from the last bit's sample).
- cnt_ready while EMPTY is ignored.
- bit_valid=0 cycles are stalls: no state change except output handshake.
- match_in is ignored when bit_valid=0.

Test Plan:
1. Reset, then stream 16 bits "1010 0000 0000 0101" with bit_valid every cycle, cnt_ready=1 -> one cnt_valid pulse after the 16th bit; cnt_out=2, frame_num=0, cnt_sat=0, overflow=0.
2. Three back-to-back frames with match_in=1 on 3, 0, 5 bits, cnt_ready=0 until the third completes -> cnt_out=3, frame_num=0 held stable; overflow=1 after the 2nd frame's completion; after the handshake cnt_out=5, frame_num=2. Completion and handshake in the same cycle keep cnt_valid high with no bubble.
3. CNT_W=2, match_in=1 on all 16 bits -> cnt_out=3, cnt_sat=1; the next frame with 1 match -> cnt_out=1, cnt_sat=0.
4. frame_sync=1 at bit 9 of a frame with 4 matches so far, together with bit_valid=1 and match_in=1 -> no result for the aborted frame. The next result appears 15 bit_valid cycles later, counts the sync-cycle match, and frame_num is unchanged from the aborted frame's.
5. Alternate bit_valid 1/0 (half-rate), plus reset asserted at bit 7 with cnt_valid=1 pending -> all outputs 0 the next cycle; the first frame after reset needs 16 valid bits and reports frame_num=0.
6. Stream 257 frames with cnt_ready=1 -> frame_num sequence 0..255,0; overflow stays 0.
